traffic_signal_controller_timed: RTL and testbench
==================================================

Name: traffic_signal_controller_timed

Overview:
Parametrised successor to the two-road highway/country traffic signal controller. It adds programmable phase durations, a minimum/maximum green policy and a latched pedestrian walk request. It also adds an emergency pre-emption input that forces the highway to green. It sits at the top of the intersection controller and drives the highway, country-road and walk lamp drivers directly.

Parameters:
CNT_W, 4, width of the phase timer; every duration parameter must be in 1..2**CNT_W-1.
MIN_GREEN, 4, minimum cycles either road stays green before it may yield.
MAX_COUNTRY_GREEN, 8, maximum country-road green cycles; must be >= MIN_GREEN.
YELLOW_CYCLES, 3, cycles spent in each yellow phase.
Y2R_DELAY, 2, all-red cycles after highway yellow.
R2G_DELAY, 2, all-red cycles before highway returns to green.
WALK_CYCLES, 5, cycles the walk lamp is lit.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-low reset.
x  input  1  car present on country road (1 = car waiting).
ped_req  input  1  pedestrian push-button; level or pulse, latched internally.
emergency  input  1  emergency pre-emption; forces highway green.
hwy  output  2  highway lamp: 2'd0 RED, 2'd1 YELLOW, 2'd2 GREEN.
country  output  2  country lamp, same encoding.
walk  output  1  pedestrian walk lamp.
state_o  output  3  current FSM state encoding, for debug.

Behaviour:
- Reset: one clock and reset are shared by the whole block. The reset is synchronous and active-low.
- Values while reset=0 at a rising edge: state=S0, timer=0, ped_pending=0, hwy=2'd2, country=2'd0, walk=0, state_o=0.
- Reset wins over every other input. Reset asserted mid-phase returns the block to S0 at the next edge.
- Outputs are Moore, decoded from the state register only, so lamps change on the edge the state changes.
- The encoding 2'd3 is never driven.
- Timer: counts cycles in the current state and clears to 0 on every state change.
  - It saturates at all-ones.
  - "Hold D cycles" means the transition is taken at the edge where timer==D-1, so the state is visible for exactly D cycles.
- ped_pending: set at any edge where ped_req=1 and state!=S6. It clears on the edge that enters S6. A ped_req seen while in S6 is ignored.
- States and outputs (hwy/country/walk):
  - S0 HWY_GREEN (2/0/0).
  - S1 HWY_YELLOW (1/0/0).
  - S2 ALL_RED_A (0/0/0).
  - S3 COUNTRY_GREEN (0/2/0).
  - S4 COUNTRY_YELLOW (0/1/0).
  - S5 ALL_RED_B (0/0/0).
  - S6 PED_WALK (0/0/1).
- Transitions:
  - S0->S1 when timer>=MIN_GREEN-1 and (x or ped_pending) and emergency=0. Otherwise hold S0; the highway holds indefinitely with no demand.
  - S1->S2 after YELLOW_CYCLES.
  - S2, after Y2R_DELAY, takes the first true branch: emergency -> S0; ped_pending -> S6; x -> S3; else S0.
  - S3->S4 on any of: emergency=1 (immediately, ignoring MIN_GREEN); x=0 and timer>=MIN_GREEN-1; timer==MAX_COUNTRY_GREEN-1.
  - S4->S5 after YELLOW_CYCLES.
  - S5->S0 after R2G_DELAY.
  - S6->S5 after WALK_CYCLES.
  - Emergency does not abort S1, S2, S4, S5 or S6 early: yellow and all-red phases are always served in full for safety.
- Simultaneous events:
  - In S2, pedestrian is served before the car.
  - A car still waiting after S6 is served on the next S0 exit.
  - In S3, emergency and the max timeout coinciding give a single transition to S4.
- Invariant: never hwy!=RED and country!=RED in the same cycle. walk=1 only when both are RED.

Test Plan:
1. reset=0 for 5 negedges, then x=0, ped_req=0, emergency=0 for 20 cycles -> hwy=2, country=0, walk=0, state_o=0 throughout.
2. After 10 cycles in S0, set x=1 and hold it, then drop x after entry to S3 -> next edge hwy=1 for 3 cycles; then 0/0 for 2 cycles; then country=2 for exactly 4 cycles (MIN_GREEN) after x drops; then country=1 for 3, all red 2, hwy=2.
3. x=1 held 40 cycles -> country=2 for exactly 8 cycles (MAX), yellow 3, all-red 2, hwy=2 for exactly 4 cycles, then hwy=1 again; the cycle repeats.
4. 1-cycle ped_req pulse with x=0 in S0 (timer>=3) -> hwy=1 for 3 cycles, all red 2, walk=1 for 5 cycles, all red 2, hwy=2; no country green; ped_pending=0 afterwards.
5. emergency=1 raised on the 2nd cycle of S3 while x=1 -> country=1 at the next edge for 3 cycles, all red 2, then hwy=2 stays green for as long as emergency=1 despite x=1. When emergency=0, S0 exits after MIN_GREEN.
6. reset=0 for one edge while in S4 with ped_pending=1 -> next cycle hwy=2, country=0, walk=0, state_o=0; with ped_req=0 and x=0, no walk phase follows.

Source files
------------

// File: rtl/traffic_signal_controller_timed.sv
// Two-road highway/country signal controller with programmable phase timing,
// min/max green policy, latched pedestrian walk and emergency highway pre-emption.
module traffic_signal_controller_timed #(
  parameter int CNT_W             = 4,
  parameter int MIN_GREEN         = 4,
  parameter int MAX_COUNTRY_GREEN = 8,
  parameter int YELLOW_CYCLES     = 3,
  parameter int Y2R_DELAY         = 2,
  parameter int R2G_DELAY         = 2,
  parameter int WALK_CYCLES       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  input  logic       ped_req,
  input  logic       emergency,
  output logic [1:0] hwy,
  output logic [1:0] country,
  output logic       walk,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // HWY_GREEN
    S1 = 3'd1,  // HWY_YELLOW
    S2 = 3'd2,  // ALL_RED_A
    S3 = 3'd3,  // COUNTRY_GREEN
    S4 = 3'd4,  // COUNTRY_YELLOW
    S5 = 3'd5,  // ALL_RED_B
    S6 = 3'd6   // PED_WALK
  } state_t;

  localparam logic [1:0] RED = 2'd0;
  localparam logic [1:0] YEL = 2'd1;
  localparam logic [1:0] GRN = 2'd2;

  // Terminal timer values: a phase held D cycles leaves when timer == D-1.
  localparam logic [CNT_W-1:0] MIN_T  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAXC_T = CNT_W'(MAX_COUNTRY_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_T  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y2R_T  = CNT_W'(Y2R_DELAY - 1);
  localparam logic [CNT_W-1:0] R2G_T  = CNT_W'(R2G_DELAY - 1);
  localparam logic [CNT_W-1:0] WALK_T = CNT_W'(WALK_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer;
  logic             ped_pending;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S0;
      timer       <= '0;
      ped_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + 1'b1;
      // Entering the walk phase consumes the request, even if pressed again now.
      if (state_nxt == S6 && state != S6)
        ped_pending <= 1'b0;
      else if (ped_req && state != S6)
        ped_pending <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S0: if (timer >= MIN_T && (x || ped_pending) && !emergency) state_nxt = S1;
      S1: if (timer == YEL_T) state_nxt = S2;
      S2: begin
        if (timer == Y2R_T) begin
          if (emergency)        state_nxt = S0;
          else if (ped_pending) state_nxt = S6;
          else if (x)           state_nxt = S3;
          else                  state_nxt = S0;
        end
      end
      S3: if (emergency || (!x && timer >= MIN_T) || timer == MAXC_T) state_nxt = S4;
      S4: if (timer == YEL_T) state_nxt = S5;
      S5: if (timer == R2G_T) state_nxt = S0;
      S6: if (timer == WALK_T) state_nxt = S5;
      default: state_nxt = S0;
    endcase
  end

  always_comb begin
    hwy     = RED;
    country = RED;
    walk    = 1'b0;
    state_o = state;
    unique case (state)
      S0: hwy     = GRN;
      S1: hwy     = YEL;
      S3: country = GRN;
      S4: country = YEL;
      S6: walk    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_signal_controller_timed.sv
// Scoreboard bench: a phase/dwell reference model predicts every cycle's lamps,
// a monitor compares the DUT against the queued predictions.
module tb_traffic_signal_controller_timed;

  localparam int MIN_GREEN = 4, MAX_CG = 8, YEL = 3, Y2R = 2, R2G = 2, WALKC = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       x = 1'b0, ped_req = 1'b0, emergency = 1'b0;
  logic [1:0] hwy, country;
  logic       walk;
  logic [2:0] state_o;

  traffic_signal_controller_timed dut (
    .clk(clk), .reset(reset), .x(x), .ped_req(ped_req), .emergency(emergency),
    .hwy(hwy), .country(country), .walk(walk), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Reference model: phase number (0..6), cycles already spent in it, pending walk.
  int ph = 0, dwell = 0;
  bit ped = 0;
  int hwy_tab[7]  = '{2, 1, 0, 0, 0, 0, 0};
  int ctry_tab[7] = '{0, 0, 0, 2, 1, 0, 0};

  task automatic model_step(input bit r, input bit xx, input bit p, input bit e);
    int nph;
    int held;
    if (!r) begin
      ph = 0; dwell = 0; ped = 0;
    end else begin
      held = dwell + 1;
      nph = ph;
      case (ph)
        0: if (held >= MIN_GREEN && (xx || ped) && !e) nph = 1;
        1: if (held == YEL) nph = 2;
        2: if (held == Y2R) nph = e ? 0 : (ped ? 6 : (xx ? 3 : 0));
        3: if (e || (!xx && held >= MIN_GREEN) || held == MAX_CG) nph = 4;
        4: if (held == YEL) nph = 5;
        5: if (held == R2G) nph = 0;
        default: if (held == WALKC) nph = 5;
      endcase
      if (nph == 6 && ph != 6) ped = 0;
      else if (p && ph != 6) ped = 1;
      dwell = (nph != ph) ? 0 : dwell + 1;
      ph = nph;
    end
  endtask

  task automatic apply(input bit r, input bit xx, input bit p, input bit e);
    @(negedge clk);
    reset = r; x = xx; ped_req = p; emergency = e;
    model_step(r, xx, p, e);
    exp_q.push_back({2'(hwy_tab[ph]), 2'(ctry_tab[ph]), (ph == 6), 3'(ph)});
  endtask

  task automatic run(input int n, input bit r, input bit xx, input bit p, input bit e);
    for (int i = 0; i < n; i++) apply(r, xx, p, e);
  endtask

  always begin
    logic [7:0] e;
    logic [7:0] got;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {hwy, country, walk, state_o};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got hwy=%0d country=%0d walk=%0d state=%0d exp hwy=%0d country=%0d walk=%0d state=%0d",
                 $time, hwy, country, walk, state_o, e[7:6], e[5:4], e[3], e[2:0]);
      end
      checks++;
      if ((hwy != 2'd0 && country != 2'd0) || (walk && (hwy != 2'd0 || country != 2'd0))) begin
        errors++;
        $display("FAIL safety t=%0t got hwy=%0d country=%0d walk=%0d exp conflict-free lamps",
                 $time, hwy, country, walk);
      end
    end
  end

  initial begin
    // Reset, then idle highway green.
    run(5, 0, 0, 0, 0);
    run(30, 1, 0, 0, 0);
    // Car arrives, leaves after country green starts.
    for (int i = 0; i < 40 && ph != 3; i++) apply(1, 1, 0, 0);
    run(15, 1, 0, 0, 0);
    // Continuous car demand: max-green cycling.
    run(40, 1, 1, 0, 0);
    run(15, 1, 0, 0, 0);
    // Single pedestrian pulse, walk phase only.
    apply(1, 0, 1, 0);
    run(20, 1, 0, 0, 0);
    // Emergency during country green keeps highway green.
    for (int i = 0; i < 40 && ph != 3; i++) apply(1, 1, 0, 0);
    apply(1, 1, 0, 0);
    run(30, 1, 1, 0, 1);
    run(20, 1, 1, 0, 0);
    // Reset in country yellow with a pending walk request.
    for (int i = 0; i < 40 && ph != 4; i++) apply(1, 1, (ph == 3), 0);
    apply(0, 1, 0, 0);
    run(20, 1, 0, 0, 0);
    // Randomised segments.
    for (int s = 0; s < 250; s++) begin
      int len;
      bit r, xx, e;
      len = $urandom_range(1, 18);
      r   = ($urandom_range(0, 59) != 0);
      xx  = $urandom_range(0, 1);
      e   = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < len; i++)
        apply(r, xx, ($urandom_range(0, 9) == 0), e);
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
